// File: rtl/blackjack_pkg.sv
// Shared blackjack definitions: card rank constants, hand limits, the
// dealer FSM state encoding, its debug view, and small hand arithmetic helpers.
package blackjack_pkg;

  localparam logic [3:0] RANK_ACE      = 4'd1;
  localparam logic [3:0] RANK_TEN      = 4'd10;
  localparam logic [3:0] RANK_KING     = 4'd13;
  localparam logic [4:0] BLACKJACK_VAL = 5'd21;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    REQ   = 3'd2,
    ADD   = 3'd3,
    DONE  = 3'd4
  } dealer_state_e;

  // Debug view of the dealer controller: registered state plus a bust flag.
  typedef struct packed {
    dealer_state_e state;
    logic          bust;
  } dealer_dbg_t;

  // Hard total plus one card. The reachable maximum is 26, but a long run of
  // opening loads could exceed 5 bits, so the sum clamps instead of wrapping.
  function automatic logic [4:0] sat_add5(input logic [4:0] a, input logic [3:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {2'b0, b};
    return s[5] ? 5'd31 : s[4:0];
  endfunction

  // Best value: one ace promoted to 11 when that does not bust the hand.
  function automatic logic [4:0] best_value(input logic [4:0] hard, input logic ace);
    return (ace && (hard <= 5'd11)) ? (hard + 5'd10) : hard;
  endfunction

  // An ace counted as 11 makes the hand soft.
  function automatic logic is_soft(input logic [4:0] hard, input logic ace);
    return ace && (hard <= 5'd11);
  endfunction

endpackage

// File: rtl/dealer_controller_if.sv
// Dealer-turn bus: start/busy/done handshake with the state controller, the
// opening-card load from the deal controller, the card-source draw handshake
// and the hand-value outputs.
//
// Handshake rules:
//   - dealerStart is a one-cycle pulse, only honoured while the dealer is idle.
//   - dealerOn stays high for the whole turn.
//   - dealerDone pulses for one cycle at the end of the turn.
//   - cardReq is a level held high until a card arrives.
//   - A card transfers on the rising edge where cardReq && cardValid; cardValid
//     without cardReq is ignored.
//   - loadValid transfers loadRank on any rising edge while idle.
interface dealer_controller_if;
  logic       dealerStart;
  logic       dealerOn;
  logic       dealerDone;
  logic       refresh;
  logic       loadValid;
  logic [3:0] loadRank;
  logic       cardReq;
  logic       cardValid;
  logic [3:0] cardRank;
  logic [4:0] dealerHandVal;
  logic       dealerSoft;
  logic [3:0] cardCount;

  // Initiator side: state controller, deal controller and card source.
  modport master (
    output dealerStart, refresh, loadValid, loadRank, cardValid, cardRank,
    input  dealerOn, dealerDone, cardReq, dealerHandVal, dealerSoft, cardCount
  );

  // Responder side: the dealer controller itself.
  modport slave (
    input  dealerStart, refresh, loadValid, loadRank, cardValid, cardRank,
    output dealerOn, dealerDone, cardReq, dealerHandVal, dealerSoft, cardCount
  );
endinterface

// File: rtl/dealer_controller_card_points.sv
// card_points: maps a 4-bit card rank to its hard point value. Ace counts 1,
// 2..10 count face value, and court cards plus unused codes count 10.
module card_points
  import blackjack_pkg::*;
(
  input  logic [3:0] rank,
  output logic [3:0] points
);

  // Out-of-range codes (0, 14, 15) fall through to the 10-point default.
  always_comb begin
    points = 4'd10;
    if ((rank >= RANK_ACE) && (rank <= RANK_KING)) begin
      points = (rank > RANK_TEN) ? 4'd10 : rank;
    end
  end

endmodule

// File: rtl/dealer_controller.sv
// dealer_controller: plays the dealer turn. Opening cards load while idle; a
// dealerStart pulse runs CHECK/REQ/ADD until the best value reaches STAND_VAL,
// then DONE pulses and the controller returns to idle.
// Optional build macro DEALER_HIT_SOFT17_EN makes the dealer hit a soft 17;
// without it the dealer stands on every value >= STAND_VAL.
module dealer_controller
  import blackjack_pkg::*;
#(
  parameter int STAND_VAL = 17,
  parameter int MAX_CARDS = 15
) (
  input  logic                Clock,
  input  logic                ResetN,
  dealer_controller_if.slave  bus,
  output dealer_dbg_t         dbg
);

  localparam logic [5:0] STAND_V = 6'(STAND_VAL);
  localparam logic [3:0] MAX_C   = 4'(MAX_CARDS);

  dealer_state_e stateQ;
  dealer_state_e stateD;

  logic [4:0] hardTotal;
  logic       hasAce;
  logic [3:0] cardCountQ;
  logic [3:0] latchRank;

  logic [3:0] loadPoints;
  logic [3:0] drawPoints;
  logic       addEn;
  logic [3:0] addPoints;
  logic       addIsAce;
  logic [4:0] addSum;

  logic [4:0] handVal;
  logic       handSoft;
  logic       atStand;
  logic       standNow;

  logic       onD;
  logic       reqD;
  logic       doneD;

  card_points uLoadPoints (
    .rank   (bus.loadRank),
    .points (loadPoints)
  );

  card_points uDrawPoints (
    .rank   (latchRank),
    .points (drawPoints)
  );

  // Best hand value, soft flag and the stand decision used in CHECK.
  always_comb begin
    handVal  = best_value(hardTotal, hasAce);
    handSoft = is_soft(hardTotal, hasAce);
    atStand  = ({1'b0, handVal} >= STAND_V);
`ifdef DEALER_HIT_SOFT17_EN
    standNow = atStand && !(handSoft && (handVal == 5'd17));
`else
    standNow = atStand;
`endif
  end

  // Select which card, if any, joins the hand this cycle: an opening load
  // while idle, or the latched draw in ADD.
  always_comb begin
    addEn     = 1'b0;
    addPoints = 4'd0;
    addIsAce  = 1'b0;
    if ((stateQ == IDLE) && bus.loadValid) begin
      addEn     = 1'b1;
      addPoints = loadPoints;
      addIsAce  = (bus.loadRank == RANK_ACE);
    end else if (stateQ == ADD) begin
      addEn     = 1'b1;
      addPoints = drawPoints;
      addIsAce  = (latchRank == RANK_ACE);
    end
    addSum = sat_add5(hardTotal, addPoints);
  end

  // FSM state register.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // FSM next state and Moore outputs; refresh overrides every transition.
  always_comb begin
    stateD = stateQ;
    onD    = 1'b0;
    reqD   = 1'b0;
    doneD  = 1'b0;
    case (stateQ)
      IDLE: begin
        if (bus.dealerStart) stateD = CHECK;
      end
      CHECK: begin
        onD    = 1'b1;
        stateD = standNow ? DONE : REQ;
      end
      REQ: begin
        onD  = 1'b1;
        reqD = 1'b1;
        if (bus.cardValid) stateD = ADD;
      end
      ADD: begin
        onD    = 1'b1;
        stateD = CHECK;
      end
      DONE: begin
        doneD  = 1'b1;
        stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
    if (bus.refresh) stateD = IDLE;
  end

  // Hand registers and draw latch; refresh clears them like reset does.
  always_ff @(posedge Clock) begin
    if (!ResetN || bus.refresh) begin
      hardTotal  <= 5'd0;
      hasAce     <= 1'b0;
      cardCountQ <= 4'd0;
      latchRank  <= 4'd0;
    end else begin
      if (addEn) begin
        hardTotal <= addSum;
        hasAce    <= hasAce | addIsAce;
        if (cardCountQ < MAX_C) cardCountQ <= cardCountQ + 4'd1;
      end
      if ((stateQ == REQ) && bus.cardValid) latchRank <= bus.cardRank;
    end
  end

  assign bus.dealerOn      = onD;
  assign bus.cardReq       = reqD;
  assign bus.dealerDone    = doneD;
  assign bus.dealerHandVal = handVal;
  assign bus.dealerSoft    = handSoft;
  assign bus.cardCount     = cardCountQ;

  assign dbg.state = stateQ;
  assign dbg.bust  = (handVal > BLACKJACK_VAL);

endmodule

// File: doc/dealer_controller.md
# dealer_controller

Responder for the dealer-turn handshake. On a one-cycle `dealerStart` pulse it holds `dealerOn` high and draws cards from the card source until the dealer hand reaches the stand threshold, then drops `dealerOn`. It maintains the dealer hand value, with ace promotion, for the round and accepts the two opening cards from the deal controller. It sits between the game state controller (initiator), the deck/card source, and the hand-value consumers.

## Interface

Parameters:
- `STAND_VAL`, default 17: dealer stands at a best value ≥ this.
- `MAX_CARDS`, default 15: saturation value of `cardCount`.

Ports:
- `Clock` in 1: single clock, rising edge.
- `ResetN` in 1: synchronous, active-low reset.
- `dealerStart` in 1: one-cycle start pulse from the state controller.
- `dealerOn` out 1: busy; high while the dealer turn is in progress.
- `dealerDone` out 1: one-cycle pulse when the turn completes.
- `refresh` in 1: clears the hand and aborts any turn.
- `loadValid` in 1: opening card from the deal controller is present.
- `loadRank` in 4: opening card rank, 1=Ace, 2..10, 11..13 = J/Q/K.
- `cardReq` out 1: request one card from the card source.
- `cardValid` in 1: the card source presents `cardRank`.
- `cardRank` in 4: drawn card rank, same encoding as `loadRank`.
- `dealerHandVal` out 5: best hand value.
- `dealerSoft` out 1: an ace is currently counted as 11.
- `cardCount` out 4: cards in hand, saturating.

## Operation

- Card points: rank 1 = 1 (ace), 2..10 = face value, 11..13 = 10. Ranks 0, 14 and 15 are treated as 10.
- Hand registers:
  - `hardTotal` is 5 bits, with every ace counted as 1. Its maximum is 26.
  - `hasAce` records that at least one ace is in hand.
- `dealerHandVal = hardTotal + 10` when `hasAce` and `hardTotal ≤ 11`; otherwise `hardTotal`. `dealerSoft` is 1 exactly in the first case.
- FSM states:
  - IDLE:
    - `loadValid` adds `loadRank` to the hand.
    - `dealerStart` → CHECK.
  - CHECK:
    - If `dealerHandVal ≥ STAND_VAL` (subject to Configuration) → DONE.
    - Otherwise → REQ.
  - REQ:
    - `cardReq` is held high.
    - On `cardValid`, latch `cardRank` → ADD.
  - ADD:
    - Add the latched card.
    - `cardCount` increments, saturating at `MAX_CARDS`.
    - → CHECK.
  - DONE: `dealerDone` = 1 → IDLE.
- Outputs are Moore outputs decoded from the registered state:
  - `dealerOn` = 1 in CHECK, REQ and ADD.
  - `cardReq` = 1 in REQ only.
- Boundary rules:
  - `dealerStart` outside IDLE is ignored.
  - `loadValid` outside IDLE is ignored.
  - `loadValid` and `dealerStart` in the same IDLE cycle: the load is applied, and CHECK evaluates the updated hand.
  - `refresh` has priority over everything except reset. In any state it clears the hand, `cardCount` and the latch, and forces IDLE.
  - `refresh` in the same cycle as `dealerStart` or `loadValid`: the refresh wins and the other input is dropped.
  - A bust (value > 21) simply ends the turn via CHECK → DONE. No value wrap is possible: the largest value is 16 + 10 = 26.
  - `cardValid` outside REQ is ignored.

## Timing

- Reset values: state IDLE; `dealerOn`, `dealerDone`, `cardReq` = 0; `dealerHandVal` = 0, `dealerSoft` = 0, `cardCount` = 0.
- `dealerStart` sampled at edge T → `dealerOn` = 1 from T+1.
- Dealer already stands: `dealerOn` falls at T+2, with `dealerDone` high for the T+2 cycle.
- Each draw costs at least 3 cycles (CHECK, REQ, ADD) with zero-wait `cardValid`. REQ stretches one cycle per wait cycle.
- A loaded or drawn card is visible on `dealerHandVal` on the cycle after the load or ADD.

## Configuration

- `DEALER_HIT_SOFT17_EN`
  - Defined: in CHECK, a soft 17 (`dealerSoft` = 1 and value = 17) → REQ. The dealer hits soft 17.
  - Undefined: every value ≥ `STAND_VAL` → DONE. The dealer stands on all 17s.

## Structure

- Shared package `blackjack_pkg`:
  - rank constants: `RANK_ACE` = 1, `RANK_KING` = 13;
  - `BLACKJACK_VAL` = 21;
  - the dealer FSM state enum (IDLE, CHECK, REQ, ADD, DONE).
- One sub-module, `card_points`: combinational 4-bit rank → 4-bit point value, instantiated for both the load path and the draw path.

## Test plan

- Reset then idle: `dealerOn` = 0, `dealerHandVal` = 0, `cardCount` = 0, `cardReq` never asserted.
- Load 10 and 7, pulse `dealerStart` → no `cardReq`; `dealerOn` high for one cycle; `dealerDone` pulse; value 17.
- Load 6 and 5, start, supply 3 then 4 with zero wait → two requests; value 18; `cardCount` 4; `dealerOn` falls after the last CHECK.
- Load Ace and 6, start:
  - macro undefined → stand at soft 17, `dealerSoft` = 1;
  - macro defined → draw; supplying 10 gives value 17, hard, `dealerSoft` = 0.
- Load 10 and 6, start, supply King → value 26 (bust); turn ends; no further request.
- During REQ, assert `refresh` → returns to IDLE, hand cleared, `dealerOn` = 0 next cycle. A second `dealerStart` during an active turn is ignored.
